// File: rtl/cv32e40p_obi_sram_bridge.sv
// OBI data-port responder backed by a single-port, byte-enabled synchronous SRAM.
//
// Handshake: a transfer is accepted in the cycle where req_i && gnt_o. The
// requester holds req_i and its address/control until that cycle. Each accepted
// transfer produces exactly one rvalid_o pulse RVALID_DELAY cycles later, in
// acceptance order. There is no response backpressure because OBI has no rready.
//
// Grant stalling uses a 3-bit counter, stall_q, with two states. IDLE means
// stall_q is 0. WAIT means a request is being held off. The state is kept in
// r_state and mirrored on w_fsm_state so a checker can bind to it.
// Addresses outside the SRAM window never reach the SRAM. Reads outside the
// window return OOB_RDATA. Writes outside the window are dropped and return 0.
module cv32e40p_obi_sram_bridge #(
    parameter int unsigned ADDR_WIDTH   = 14,
    parameter logic [31:0] BASE_ADDR    = 32'h0001_0000,
    parameter int unsigned GNT_DELAY    = 0,
    parameter int unsigned RVALID_DELAY = 1,
    parameter logic [31:0] OOB_RDATA    = 32'hDEAD_BEEF
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_i,
    output logic                  gnt_o,
    input  logic [31:0]           addr_i,
    input  logic                  we_i,
    input  logic [3:0]            be_i,
    input  logic [31:0]           wdata_i,
    output logic                  rvalid_o,
    output logic [31:0]           rdata_o,
    output logic                  sram_req_o,
    output logic                  sram_we_o,
    output logic [3:0]            sram_be_o,
    output logic [ADDR_WIDTH-1:0] sram_addr_o,
    output logic [31:0]           sram_wdata_o,
    input  logic [31:0]           sram_rdata_i
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    localparam logic [2:0]  GNT_DLY3  = 3'(GNT_DELAY);
    // The window size in bytes needs 33 bits so that ADDR_WIDTH up to 30 still fits.
    localparam logic [32:0] WIN_BYTES = 33'(64'd4 << ADDR_WIDTH);

    state_e      r_state;
    state_e      w_state_nxt;
    logic [2:0]  r_stall_q;
    logic [2:0]  w_stall_nxt;
    logic        w_gnt;
    logic        w_fsm_state;

    logic [31:0] w_offset;
    logic        w_in_win;

    logic        r_s1_valid;
    logic        r_s1_we;
    logic        r_s1_oob;
    logic [31:0] w_s1_data;

    assign w_fsm_state = r_state;

    // State register: stall counter and FSM state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= ST_IDLE;
            r_stall_q <= 3'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_stall_q <= w_stall_nxt;
        end
    end

    // Next state: count the stalled cycles of a held request, and clear the counter on grant or when req_i drops
    always_comb begin
        w_state_nxt = r_state;
        w_stall_nxt = r_stall_q;
        if (GNT_DELAY == 0) begin
            w_state_nxt = ST_IDLE;
            w_stall_nxt = 3'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_i && !w_gnt) begin
                        w_state_nxt = ST_WAIT;
                        w_stall_nxt = r_stall_q + 3'd1;
                    end
                end
                ST_WAIT: begin
                    if (!req_i || w_gnt) begin
                        w_state_nxt = ST_IDLE;
                        w_stall_nxt = 3'd0;
                    end else begin
                        w_stall_nxt = r_stall_q + 3'd1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_stall_nxt = 3'd0;
                end
            endcase
        end
    end

    // Output: the grant fires when the counter has reached the configured stall
    always_comb begin
        w_gnt = 1'b0;
        if (GNT_DELAY == 0) begin
            w_gnt = req_i;
        end else begin
            w_gnt = req_i && (r_stall_q == GNT_DLY3);
        end
    end

    assign gnt_o = w_gnt;

    // Window check. The subtraction wraps at 32 bits, so addresses below BASE_ADDR fall out of the window.
    assign w_offset    = addr_i - BASE_ADDR;
    assign w_in_win    = ({1'b0, w_offset} < WIN_BYTES);
    assign sram_addr_o = w_offset[ADDR_WIDTH+1:2];

    // SRAM strobe in the grant cycle. Byte enables are masked whenever no access happens.
    always_comb begin
        sram_req_o   = w_gnt && w_in_win;
        sram_we_o    = we_i;
        sram_wdata_o = wdata_i;
        sram_be_o    = sram_req_o ? be_i : 4'b0000;
    end

    // Response stage 1: capture the grant, direction and window result for the next cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s1_valid <= 1'b0;
            r_s1_we    <= 1'b0;
            r_s1_oob   <= 1'b0;
        end else begin
            r_s1_valid <= w_gnt;
            r_s1_we    <= we_i;
            r_s1_oob   <= !w_in_win;
        end
    end

    // Stage-1 data is resolved when the SRAM read data is valid. The value is zero unless a read response is present.
    always_comb begin
        w_s1_data = 32'd0;
        if (r_s1_valid && !r_s1_we) begin
            w_s1_data = r_s1_oob ? OOB_RDATA : sram_rdata_i;
        end
    end

    generate
        if (RVALID_DELAY == 1) begin : g_rv_direct
            assign rvalid_o = r_s1_valid;
            assign rdata_o  = w_s1_data;
        end else begin : g_rv_tail
            localparam int unsigned TAIL = RVALID_DELAY - 1;

            logic [TAIL-1:0] r_tail_vld;
            logic [31:0]     r_tail_dat [TAIL];

            // Stages 2..N: an unconditional shift register of resolved responses
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_tail_vld <= '0;
                    for (int i = 0; i < int'(TAIL); i++) begin
                        r_tail_dat[i] <= 32'd0;
                    end
                end else begin
                    r_tail_vld[0] <= r_s1_valid;
                    r_tail_dat[0] <= w_s1_data;
                    for (int i = 1; i < int'(TAIL); i++) begin
                        r_tail_vld[i] <= r_tail_vld[i-1];
                        r_tail_dat[i] <= r_tail_dat[i-1];
                    end
                end
            end

            assign rvalid_o = r_tail_vld[TAIL-1];
            assign rdata_o  = r_tail_dat[TAIL-1];
        end
    endgenerate

endmodule

// File: tb/tb_cv32e40p_obi_sram_bridge.sv
// Directed bench for cv32e40p_obi_sram_bridge. It uses three instances:
//   dut_a: GNT_DELAY=0, RVALID_DELAY=1 (single access, byte enables, window edges)
//   dut_b: GNT_DELAY=3, RVALID_DELAY=4 (stall/latency, reset mid-flight)
//   dut_c: GNT_DELAY=0, RVALID_DELAY=3 (back-to-back reads)
// Each instance has its own behavioural synchronous SRAM.
module tb_cv32e40p_obi_sram_bridge;

  localparam int          AW    = 14;
  localparam logic [31:0] BASE  = 32'h0001_0000;
  localparam int          DEPTH = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- dut_a signals ----------------
  logic          a_rst_n, a_req, a_gnt, a_we, a_rvalid, a_sram_req, a_sram_we;
  logic [31:0]   a_addr, a_wdata, a_rdata, a_sram_wdata, a_sram_rdata;
  logic [3:0]    a_be, a_sram_be;
  logic [AW-1:0] a_sram_addr;
  logic [31:0]   mem_a [DEPTH];

  // ---------------- dut_b signals ----------------
  logic          b_rst_n, b_req, b_gnt, b_we, b_rvalid, b_sram_req, b_sram_we;
  logic [31:0]   b_addr, b_wdata, b_rdata, b_sram_wdata, b_sram_rdata;
  logic [3:0]    b_be, b_sram_be;
  logic [AW-1:0] b_sram_addr;
  logic [31:0]   mem_b [DEPTH];

  // ---------------- dut_c signals ----------------
  logic          c_rst_n, c_req, c_gnt, c_we, c_rvalid, c_sram_req, c_sram_we;
  logic [31:0]   c_addr, c_wdata, c_rdata, c_sram_wdata, c_sram_rdata;
  logic [3:0]    c_be, c_sram_be;
  logic [AW-1:0] c_sram_addr;
  logic [31:0]   mem_c [DEPTH];

  cv32e40p_obi_sram_bridge #(
    .ADDR_WIDTH(AW), .BASE_ADDR(BASE), .GNT_DELAY(0), .RVALID_DELAY(1), .OOB_RDATA(32'hDEAD_BEEF)
  ) dut_a (
    .clk_i(clk), .rst_ni(a_rst_n), .req_i(a_req), .gnt_o(a_gnt), .addr_i(a_addr),
    .we_i(a_we), .be_i(a_be), .wdata_i(a_wdata), .rvalid_o(a_rvalid), .rdata_o(a_rdata),
    .sram_req_o(a_sram_req), .sram_we_o(a_sram_we), .sram_be_o(a_sram_be),
    .sram_addr_o(a_sram_addr), .sram_wdata_o(a_sram_wdata), .sram_rdata_i(a_sram_rdata)
  );

  cv32e40p_obi_sram_bridge #(
    .ADDR_WIDTH(AW), .BASE_ADDR(BASE), .GNT_DELAY(3), .RVALID_DELAY(4), .OOB_RDATA(32'hDEAD_BEEF)
  ) dut_b (
    .clk_i(clk), .rst_ni(b_rst_n), .req_i(b_req), .gnt_o(b_gnt), .addr_i(b_addr),
    .we_i(b_we), .be_i(b_be), .wdata_i(b_wdata), .rvalid_o(b_rvalid), .rdata_o(b_rdata),
    .sram_req_o(b_sram_req), .sram_we_o(b_sram_we), .sram_be_o(b_sram_be),
    .sram_addr_o(b_sram_addr), .sram_wdata_o(b_sram_wdata), .sram_rdata_i(b_sram_rdata)
  );

  cv32e40p_obi_sram_bridge #(
    .ADDR_WIDTH(AW), .BASE_ADDR(BASE), .GNT_DELAY(0), .RVALID_DELAY(3), .OOB_RDATA(32'hDEAD_BEEF)
  ) dut_c (
    .clk_i(clk), .rst_ni(c_rst_n), .req_i(c_req), .gnt_o(c_gnt), .addr_i(c_addr),
    .we_i(c_we), .be_i(c_be), .wdata_i(c_wdata), .rvalid_o(c_rvalid), .rdata_o(c_rdata),
    .sram_req_o(c_sram_req), .sram_we_o(c_sram_we), .sram_be_o(c_sram_be),
    .sram_addr_o(c_sram_addr), .sram_wdata_o(c_sram_wdata), .sram_rdata_i(c_sram_rdata)
  );

  // Behavioural SRAMs: byte-masked write, read data one cycle after the strobe
  always @(posedge clk) begin
    if (a_sram_req) begin
      a_sram_rdata <= mem_a[a_sram_addr];
      for (int i = 0; i < 4; i++) if (a_sram_we && a_sram_be[i]) mem_a[a_sram_addr][8*i +: 8] = a_sram_wdata[8*i +: 8];
    end
  end

  always @(posedge clk) begin
    if (b_sram_req) begin
      b_sram_rdata <= mem_b[b_sram_addr];
      for (int i = 0; i < 4; i++) if (b_sram_we && b_sram_be[i]) mem_b[b_sram_addr][8*i +: 8] = b_sram_wdata[8*i +: 8];
    end
  end

  always @(posedge clk) begin
    if (c_sram_req) begin
      c_sram_rdata <= mem_c[c_sram_addr];
      for (int i = 0; i < 4; i++) if (c_sram_we && c_sram_be[i]) mem_c[c_sram_addr][8*i +: 8] = c_sram_wdata[8*i +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive point: 1 ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sample point: after combinational paths settle on the newly driven inputs
  task automatic settle();
    #1;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_a[i] = 32'd0;
      mem_b[i] = 32'd0;
      mem_c[i] = 32'd0;
    end
    mem_a[0]      = 32'h0102_0304;
    mem_a[DEPTH-1] = 32'h600D_F00D;
    mem_b[0]      = 32'h5A5A_1234;
    mem_b[1]      = 32'h1111_0001;
    for (int i = 0; i < 5; i++) mem_c[i] = 32'(i);
    a_sram_rdata = 32'd0; b_sram_rdata = 32'd0; c_sram_rdata = 32'd0;

    a_rst_n = 1'b0; a_req = 1'b0; a_we = 1'b0; a_addr = 32'd0; a_be = 4'h0; a_wdata = 32'd0;
    b_rst_n = 1'b0; b_req = 1'b0; b_we = 1'b0; b_addr = 32'd0; b_be = 4'h0; b_wdata = 32'd0;
    c_rst_n = 1'b0; c_req = 1'b0; c_we = 1'b0; c_addr = 32'd0; c_be = 4'h0; c_wdata = 32'd0;

    // ---- reset state ----
    repeat (3) tick();
    b_req = 1'b1;
    settle();
    chk("rst_a_gnt",     32'(a_gnt),      32'd0);
    chk("rst_a_sreq",    32'(a_sram_req), 32'd0);
    chk("rst_a_sbe",     32'(a_sram_be),  32'd0);
    chk("rst_a_rvalid",  32'(a_rvalid),   32'd0);
    chk("rst_a_rdata",   a_rdata,         32'd0);
    chk("rst_b_gnt_req", 32'(b_gnt),      32'd0);
    chk("rst_b_rvalid",  32'(b_rvalid),   32'd0);
    chk("rst_c_rvalid",  32'(c_rvalid),   32'd0);
    tick();
    b_req = 1'b0;
    a_rst_n = 1'b1; b_rst_n = 1'b1; c_rst_n = 1'b1;
    tick();

    // ---- 1: single write then read (dut_a) ----
    a_req = 1'b1; a_we = 1'b1; a_addr = BASE + 32'd8; a_be = 4'hF; a_wdata = 32'hCAFE_F00D;
    settle();
    chk("t1_wr_gnt",    32'(a_gnt),       32'd1);
    chk("t1_wr_sreq",   32'(a_sram_req),  32'd1);
    chk("t1_wr_sweaddr", 32'(a_sram_addr), 32'd2);
    chk("t1_wr_sbe",    32'(a_sram_be),   32'hF);
    chk("t1_wr_swdata", a_sram_wdata,     32'hCAFE_F00D);
    chk("t1_pre_rvalid", 32'(a_rvalid),   32'd0);
    tick();
    a_we = 1'b0; a_wdata = 32'd0;
    settle();
    chk("t1_wr_rvalid", 32'(a_rvalid),    32'd1);
    chk("t1_wr_rdata",  a_rdata,          32'd0);
    chk("t1_rd_gnt",    32'(a_gnt),       32'd1);
    chk("t1_rd_saddr",  32'(a_sram_addr), 32'd2);
    tick();
    a_req = 1'b0;
    settle();
    chk("t1_rd_rvalid", 32'(a_rvalid),    32'd1);
    chk("t1_rd_rdata",  a_rdata,          32'hCAFE_F00D);
    tick();
    settle();
    chk("t1_idle_rvalid", 32'(a_rvalid),  32'd0);
    chk("t1_idle_rdata",  a_rdata,        32'd0);

    // ---- 2: byte enables (dut_a) ----
    tick();
    a_req = 1'b1; a_we = 1'b1; a_addr = BASE + 32'd16; a_be = 4'hF; a_wdata = 32'h1122_3344;
    tick();
    a_be = 4'b0100; a_wdata = 32'hAAAA_AAAA;
    settle();
    chk("t2_sbe_partial", 32'(a_sram_be), 32'h4);
    tick();
    a_we = 1'b0; a_be = 4'hF; a_wdata = 32'd0;
    settle();
    chk("t2_wr_rvalid", 32'(a_rvalid), 32'd1);
    chk("t2_wr_rdata",  a_rdata,       32'd0);
    tick();
    a_req = 1'b0;
    settle();
    chk("t2_rd_rvalid", 32'(a_rvalid), 32'd1);
    chk("t2_rd_rdata",  a_rdata,       32'h11AA_3344);

    // ---- 5: out of window, plus last in-window word (dut_a) ----
    tick();
    a_req = 1'b1; a_we = 1'b0; a_addr = BASE - 32'd4; a_be = 4'hF;
    settle();
    chk("t5_rd_gnt",  32'(a_gnt),      32'd1);
    chk("t5_rd_sreq", 32'(a_sram_req), 32'd0);
    chk("t5_rd_sbe",  32'(a_sram_be),  32'd0);
    tick();
    a_we = 1'b1; a_addr = BASE + 32'(4 * DEPTH); a_wdata = 32'h1234_5678;
    settle();
    chk("t5_wr_sreq",    32'(a_sram_req), 32'd0);
    chk("t5_wr_sbe",     32'(a_sram_be),  32'd0);
    chk("t5_rd_rvalid",  32'(a_rvalid),   32'd1);
    chk("t5_rd_rdata",   a_rdata,         32'hDEAD_BEEF);
    tick();
    a_we = 1'b0; a_addr = BASE + 32'(4 * DEPTH - 4); a_wdata = 32'd0;
    settle();
    chk("t5_wr_rvalid",   32'(a_rvalid),    32'd1);
    chk("t5_wr_rdata",    a_rdata,          32'd0);
    chk("t5_last_sreq",   32'(a_sram_req),  32'd1);
    chk("t5_last_saddr",  32'(a_sram_addr), 32'(DEPTH - 1));
    tick();
    a_req = 1'b0;
    settle();
    chk("t5_last_rvalid", 32'(a_rvalid), 32'd1);
    chk("t5_last_rdata",  a_rdata,       32'h600D_F00D);
    chk("t5_word0_kept",  mem_a[0],      32'h0102_0304);

    // ---- 3: stall and latency (dut_b, GNT_DELAY=3, RVALID_DELAY=4) ----
    tick();
    b_req = 1'b1; b_we = 1'b0; b_addr = BASE; b_be = 4'hF;
    for (int k = 0; k < 10; k++) begin
      if (k == 4) b_req = 1'b0;
      settle();
      chk($sformatf("t3_gnt_k%0d", k),    32'(b_gnt),      32'(k == 3));
      chk($sformatf("t3_sreq_k%0d", k),   32'(b_sram_req), 32'(k == 3));
      chk($sformatf("t3_rvalid_k%0d", k), 32'(b_rvalid),   32'(k == 7));
      chk($sformatf("t3_rdata_k%0d", k),  b_rdata,         (k == 7) ? 32'h5A5A_1234 : 32'd0);
      tick();
    end

    // ---- 4: back-to-back reads (dut_c, GNT_DELAY=0, RVALID_DELAY=3) ----
    for (int k = 0; k < 11; k++) begin
      if (k < 5) begin
        c_req = 1'b1; c_we = 1'b0; c_addr = BASE + 32'(4 * k); c_be = 4'hF;
      end else begin
        c_req = 1'b0;
      end
      settle();
      chk($sformatf("t4_gnt_k%0d", k),    32'(c_gnt),    32'(k < 5));
      chk($sformatf("t4_rvalid_k%0d", k), 32'(c_rvalid), 32'(k >= 3 && k <= 7));
      chk($sformatf("t4_rdata_k%0d", k),  c_rdata,       (k >= 3 && k <= 7) ? 32'(k - 3) : 32'd0);
      tick();
    end

    // ---- 6: reset with responses in flight (dut_b) ----
    b_req = 1'b1; b_we = 1'b0; b_addr = BASE + 32'd4; b_be = 4'hF;
    for (int k = 0; k < 8; k++) begin
      settle();
      chk($sformatf("t6_gnt_k%0d", k),    32'(b_gnt),    32'(k == 3 || k == 7));
      chk($sformatf("t6_rvalid_k%0d", k), 32'(b_rvalid), 32'(k == 7));
      if (k == 7) chk("t6_first_rdata", b_rdata, 32'h1111_0001);
      tick();
    end
    b_req = 1'b0; b_rst_n = 1'b0;
    settle();
    chk("t6_in_reset_rvalid", 32'(b_rvalid), 32'd0);
    chk("t6_in_reset_rdata",  b_rdata,       32'd0);
    tick();
    b_rst_n = 1'b1;
    settle();
    chk("t6_release_rvalid", 32'(b_rvalid), 32'd0);
    for (int j = 0; j < 6; j++) begin
      tick();
      settle();
      chk($sformatf("t6_post_rvalid_j%0d", j), 32'(b_rvalid), 32'd0);
    end
    tick();
    b_req = 1'b1; b_we = 1'b1; b_addr = BASE + 32'd8; b_be = 4'hF; b_wdata = 32'hCAFE_F00D;
    for (int k = 0; k < 13; k++) begin
      if (k == 4) begin
        b_we = 1'b0; b_wdata = 32'd0;
      end
      if (k == 8) b_req = 1'b0;
      settle();
      chk($sformatf("t6b_gnt_k%0d", k),    32'(b_gnt),    32'(k == 3 || k == 7));
      chk($sformatf("t6b_rvalid_k%0d", k), 32'(b_rvalid), 32'(k == 7 || k == 11));
      chk($sformatf("t6b_rdata_k%0d", k),  b_rdata,       (k == 11) ? 32'hCAFE_F00D : 32'd0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
